mult_div_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit. It is the write side of the HI/LO register pair: it executes MULT, MULTU, DIV and DIVU and produces the 32-bit values (PW) and one-cycle write enables that HiRegister and LoRegister consume. It sits beside the ALU in EX. It uses a start/busy/done handshake, so the hazard unit stalls MFHI/MFLO while busy is high.

---
 rtl/mult_div_if.sv | 26 ++
 rtl/mult_div_unit.sv | 134 +++++++++++++
 tb/tb_mult_div_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// rtl/mult_div_if.sv - start/busy/done request and HI/LO write-back bundle for the multiply/divide unit
interface mult_div_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             busy;
    logic             done;
    logic             hi_enable;
    logic             lo_enable;
    logic [WIDTH-1:0] hi_pw;
    logic [WIDTH-1:0] lo_pw;
    logic             div_by_zero;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, done, hi_enable, lo_enable, hi_pw, lo_pw, div_by_zero
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, done, hi_enable, lo_enable, hi_pw, lo_pw, div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO pair
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset_n,
    mult_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   rs_raw_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               dz_q;
    logic               armed_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               in_signed;
    logic [WIDTH-1:0]   rs_abs;
    logic [WIDTH-1:0]   rt_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        in_signed = ~bus.op[0];
        rs_abs    = (in_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
        rt_abs    = (in_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
        // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        acc_d     = acc_q;
        if (!op_q[1]) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        prod_neg = -acc_q;
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            opb_q     <= '0;
            rs_raw_q  <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            armed_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            // armed_q blocks a capture on the first edge after reset release
            armed_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && armed_q) begin
                        op_q      <= bus.op;
                        opb_q     <= bus.op[1] ? rt_abs : rs_abs;
                        acc_q     <= {{WIDTH{1'b0}}, (bus.op[1] ? rs_abs : rt_abs)};
                        rs_raw_q  <= bus.rs_val;
                        neg_res_q <= in_signed & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                        neg_rem_q <= in_signed & bus.rs_val[WIDTH-1];
                        dz_q      <= bus.op[1] & (bus.rt_val == '0);
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (dz_q) begin
                        hi_q <= rs_raw_q;
                        lo_q <= '1;
                    end else if (!op_q[1]) begin
                        {hi_q, lo_q} <= neg_res_q ? prod_neg : acc_q;
                    end else begin
                        lo_q <= neg_res_q ? -quo : quo;
                        hi_q <= neg_rem_q ? -rem : rem;
                    end
                    dbz_q   <= dz_q;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi_enable   = done_q;
    assign bus.lo_enable   = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi_pw       = hi_q;
    assign bus.lo_pw       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with random and directed ops
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    mult_div_if #(.WIDTH(32)) bus ();
    mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   last_cap = 0;
    bit   synced = 1'b0;
    logic [31:0] mh = '0;
    logic [31:0] ml = '0;
    bit   prev_done = 1'b0;

    function automatic void check(input bit ok, input string name,
                                  input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    endfunction

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint      sa = longint'($signed(a));
        longint      sb_ = longint'($signed(b));
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        logic [63:0] r;
        dz = 1'b0;
        case (op)
            2'd0: r = sa * sb_;
            2'd1: r = ua * ub;
            default: begin
                if (b == 0) begin
                    dz = 1'b1;
                    r  = {a, 32'hFFFF_FFFF};
                end else if (op == 2'd2) begin
                    r[31:0]  = 32'(sa / sb_);
                    r[63:32] = 32'(sa % sb_);
                end else begin
                    r[31:0]  = 32'(ua / ub);
                    r[63:32] = 32'(ua % ub);
                end
            end
        endcase
        hi = r[63:32];
        lo = r[31:0];
    endfunction

    // monitor: pops the scoreboard on every done pulse, checks hold/strobe rules otherwise
    always @(negedge clk) begin
        if (!reset_n) begin
            mh = '0;
            ml = '0;
            prev_done = 1'b0;
        end else begin
            check(bus.hi_enable === bus.done && bus.lo_enable === bus.done, "enables_eq_done",
                  {bus.hi_enable, bus.lo_enable}, {bus.done, bus.done});
            if (bus.done === 1'b1) begin
                check(!prev_done, "done_one_cycle", 64'(prev_done), 64'd0);
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check(bus.hi_pw === e.hi, "hi_pw", bus.hi_pw, e.hi);
                    check(bus.lo_pw === e.lo, "lo_pw", bus.lo_pw, e.lo);
                    check(bus.div_by_zero === e.dz, "div_by_zero", bus.div_by_zero, e.dz);
                    check(cyc == e.cap + 33, "latency", 64'(cyc - e.cap), 64'd33);
                    mh = e.hi;
                    ml = e.lo;
                end
            end else begin
                check(bus.div_by_zero === 1'b0, "dbz_outside_done", bus.div_by_zero, 64'd0);
                check(bus.hi_pw === mh && bus.lo_pw === ml, "hold_hi_lo", {bus.hi_pw, bus.lo_pw}, {mh, ml});
            end
            prev_done = (bus.done === 1'b1);
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check(1'b0, "idle_timeout", 64'(n), 64'd100);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input bit push);
        logic [31:0] h, l;
        logic        z;
        bit          after_hold;
        after_hold = synced;
        if (!synced) wait_idle();
        synced = 1'b0;
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        @(posedge clk);
        #1;
        check(bus.busy === 1'b1, "busy_after_capture", bus.busy, 64'd1);
        if (after_hold) check(cyc == last_cap + 35, "throughput_35", 64'(cyc - last_cap), 64'd35);
        last_cap = cyc;
        if (push) begin
            model(op, a, b, h, l, z);
            sb.push_back('{hi: h, lo: l, dz: z, cap: cyc});
        end
        if (hold) begin
            int n = 0;
            while (bus.busy !== 1'b0 && n < 100) begin
                @(negedge clk);
                n++;
                bus.op     = 2'($urandom);
                bus.rs_val = $urandom;
                bus.rt_val = $urandom;
            end
            if (n >= 100) check(1'b0, "hold_timeout", 64'(n), 64'd100);
            synced = 1'b1;
        end else begin
            bus.start  = 1'b0;
            bus.rs_val = $urandom;
            bus.rt_val = $urandom;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #400_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $finish;
    end

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.rs_val = '0; bus.rt_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check(bus.busy === 1'b0 && bus.done === 1'b0, "reset_busy_done", {bus.busy, bus.done}, 64'd0);
        check(bus.hi_pw === 32'd0 && bus.lo_pw === 32'd0, "reset_hi_lo", {bus.hi_pw, bus.lo_pw}, 64'd0);
        check(bus.div_by_zero === 1'b0 && bus.hi_enable === 1'b0 && bus.lo_enable === 1'b0,
              "reset_strobes", {bus.div_by_zero, bus.hi_enable, bus.lo_enable}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        issue(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1);
        issue(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        issue(2'd3, 32'd100, 32'd7, 1'b0, 1'b1);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        issue(2'd2, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b1);
        issue(2'd3, 32'd100, 32'd0, 1'b0, 1'b1);
        issue(2'd1, 32'd3, 32'd9, 1'b0, 1'b1);
        issue(2'd0, 32'd12345, 32'hFFFF_FC00, 1'b1, 1'b1);
        issue(2'd3, 32'hDEAD_BEEF, 32'd1000, 1'b1, 1'b1);
        issue(2'd2, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick(), 1'b0, 1'b1);
        end

        issue(2'd3, 32'd100, 32'd0, 1'b0, 1'b1);
        issue(2'd3, 32'd5000, 32'd13, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check(bus.busy === 1'b0 && bus.done === 1'b0, "abort_busy_done", {bus.busy, bus.done}, 64'd0);
        check(bus.hi_pw === 32'd0 && bus.lo_pw === 32'd0, "abort_hi_lo", {bus.hi_pw, bus.lo_pw}, 64'd0);
        @(negedge clk);
        #2;
        bus.start = 1'b1; bus.op = 2'd1; bus.rs_val = 32'd6; bus.rt_val = 32'd7;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check(bus.busy === 1'b0, "start_at_reset_release", bus.busy, 64'd0);
        bus.start = 1'b0;
        issue(2'd1, 32'd6, 32'd7, 1'b0, 1'b1);

        wait_idle();
        repeat (3) @(negedge clk);
        check(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
